// File: rtl/vector_equiv_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vector_equiv_checker                                          |
// | Brief    : Applies stimulus to two combinational netlists and compares   |
// |            their results, counting mismatches and capturing the first.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module vector_equiv_checker #(
  parameter int IN_W       = 150,
  parameter int OUT_W      = 80,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vectors_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [IN_W-1:0]  vec_data_i,
  output logic [IN_W-1:0]  dut_in_o,
  input  logic [OUT_W-1:0] golden_out_i,
  input  logic [OUT_W-1:0] opt_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] mismatch_count_o,
  output logic             fail_valid_o,
  output logic [CNT_W-1:0] first_fail_idx_o,
  output logic [OUT_W-1:0] first_fail_xor_o
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    num_q;
  logic [CNT_W-1:0]    idx_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [IN_W-1:0]     dut_in_q;
  logic [CNT_W-1:0]    mismatch_q;
  logic [CNT_W-1:0]    mismatch_d;
  logic                fail_valid_q;
  logic [CNT_W-1:0]    ff_idx_q;
  logic [OUT_W-1:0]    ff_xor_q;
  logic                done_q;
  logic                pass_q;

  logic [OUT_W-1:0]    w_diff;
  logic                w_mismatch;
  logic                w_last;
  logic                w_start_ok;

  // Case inequality so that X/Z on either netlist output counts as a failure.
  assign w_diff     = golden_out_i ^ opt_out_i;
  assign w_mismatch = (golden_out_i !== opt_out_i);
  assign w_last     = (idx_q == (num_q - CNT_W'(1)));
  assign w_start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    mismatch_d = mismatch_q;
    if (w_mismatch && !(&mismatch_q)) begin
      mismatch_d = mismatch_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      idx_q        <= '0;
      settle_q     <= '0;
      dut_in_q     <= '0;
      mismatch_q   <= '0;
      fail_valid_q <= 1'b0;
      ff_idx_q     <= '0;
      ff_xor_q     <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            num_q        <= num_vectors_i;
            idx_q        <= '0;
            mismatch_q   <= '0;
            fail_valid_q <= 1'b0;
            ff_idx_q     <= '0;
            ff_xor_q     <= '0;
            if (num_vectors_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_APPLY;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end

        S_APPLY: begin
          if (vec_valid_i) begin
            dut_in_q <= vec_data_i;
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= S_COMPARE;
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end

        S_COMPARE: begin
          if (w_mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            ff_idx_q     <= idx_q;
            ff_xor_q     <= w_diff;
          end
          mismatch_q <= mismatch_d;
          if (w_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= (mismatch_d == '0);
          end else begin
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= S_APPLY;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign vec_ready_o      = (state_q == S_APPLY);
  assign busy_o           = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                            (state_q == S_COMPARE);
  assign dut_in_o         = dut_in_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign mismatch_count_o = mismatch_q;
  assign fail_valid_o     = fail_valid_q;
  assign first_fail_idx_o = ff_idx_q;
  assign first_fail_xor_o = ff_xor_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_equiv_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vector_equiv_checker                                       |
// | Brief    : Directed self-checking bench for vector_equiv_checker.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module tb_vector_equiv_checker;

  localparam int IN_W  = 150;
  localparam int OUT_W = 80;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             vec_valid;
  logic             vec_ready;
  logic [IN_W-1:0]  vec_data;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] golden_out;
  logic [OUT_W-1:0] opt_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mismatch_count;
  logic             fail_valid;
  logic [CNT_W-1:0] first_fail_idx;
  logic [OUT_W-1:0] first_fail_xor;

  logic [IN_W-1:0]  vecs [8];
  logic [OUT_W-1:0] inj  [8];
  logic             xflag[8];
  int               cur_idx;
  int               n_checks;
  int               n_errors;

  vector_equiv_checker #(
    .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SETTLE_CYC(1)
  ) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .num_vectors_i(num_vectors),
    .vec_valid_i(vec_valid), .vec_ready_o(vec_ready), .vec_data_i(vec_data),
    .dut_in_o(dut_in), .golden_out_i(golden_out), .opt_out_i(opt_out),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .mismatch_count_o(mismatch_count), .fail_valid_o(fail_valid),
    .first_fail_idx_o(first_fail_idx), .first_fail_xor_o(first_fail_xor)
  );

  always #5 clk = ~clk;

  // Stand-in netlists: golden is a fixed XOR fold; opt is golden plus injected faults.
  assign golden_out = dut_in[79:0] ^ {dut_in[149:80], 10'b0};

  always_comb begin
    opt_out = golden_out ^ inj[cur_idx];
    if (xflag[cur_idx]) opt_out[0] = 1'bx;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inj();
    for (int i = 0; i < 8; i++) begin
      inj[i]   = '0;
      xflag[i] = 1'b0;
    end
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start       = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic run_vectors(input int n, input int stall_idx,
                             input int stall_cyc, input logic [IN_W-1:0] hold);
    int c;
    for (int i = 0; i < n; i++) begin
      c = 0;
      while (!vec_ready && c < 50) begin
        @(negedge clk);
        c++;
      end
      check_eq("vec_ready", 128'(vec_ready), 128'd1);
      cur_idx = i;
      if (i == stall_idx) begin
        for (int k = 0; k < stall_cyc; k++) begin
          start       = (k == 0);
          num_vectors = 16'd7;
          @(negedge clk);
          check_eq("stall_hold", 128'(dut_in), 128'(hold));
        end
        start = 1'b0;
      end
      vec_data  = vecs[i];
      vec_valid = 1'b1;
      @(posedge clk);
      #1 vec_valid = 1'b0;
    end
    c = 0;
    while (!done && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_eq("done", 128'(done), 128'd1);
    check_eq("busy_at_done", 128'(busy), 128'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cur_idx     = 0;
    rst         = 1'b1;
    start       = 1'b0;
    num_vectors = '0;
    vec_valid   = 1'b0;
    vec_data    = '0;
    clear_inj();
    vecs[0] = '0;
    vecs[1] = '1;
    vecs[2] = {5{30'h2AAA_AAAA}};
    vecs[3] = {50{3'b101}};
    vecs[4] = 150'h1;
    vecs[5] = {75{2'b01}};
    vecs[6] = '0;
    vecs[7] = '1;

    repeat (2) @(negedge clk);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_pass", 128'(pass), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_dut_in", 128'(dut_in), 128'd0);
    rst = 1'b0;

    // T1: reset while the first vector is settling
    start_run(2);
    cur_idx   = 0;
    vec_data  = vecs[1];
    vec_valid = 1'b1;
    @(posedge clk);
    #1 vec_valid = 1'b0;
    check_eq("t1_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check_eq("t1_ready", 128'(vec_ready), 128'd0);
    check_eq("t1_busy", 128'(busy), 128'd0);
    check_eq("t1_done", 128'(done), 128'd0);
    check_eq("t1_dut_in", 128'(dut_in), 128'd0);
    check_eq("t1_count", 128'(mismatch_count), 128'd0);
    check_eq("t1_fail_valid", 128'(fail_valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // T2: empty run
    start_run(0);
    check_eq("t2_done", 128'(done), 128'd1);
    check_eq("t2_pass", 128'(pass), 128'd1);
    check_eq("t2_ready", 128'(vec_ready), 128'd0);
    @(negedge clk);
    check_eq("t2_ready_later", 128'(vec_ready), 128'd0);

    // T3: identical netlists, restart from DONE
    clear_inj();
    start_run(4);
    check_eq("t3_done_cleared", 128'(done), 128'd0);
    check_eq("t3_busy", 128'(busy), 128'd1);
    run_vectors(4, -1, 0, '0);
    check_eq("t3_pass", 128'(pass), 128'd1);
    check_eq("t3_count", 128'(mismatch_count), 128'd0);
    check_eq("t3_fail_valid", 128'(fail_valid), 128'd0);

    // T4: single-bit fault on idx 2
    clear_inj();
    inj[2] = 80'h1;
    start_run(5);
    run_vectors(5, -1, 0, '0);
    check_eq("t4_count", 128'(mismatch_count), 128'd1);
    check_eq("t4_fail_valid", 128'(fail_valid), 128'd1);
    check_eq("t4_ff_idx", 128'(first_fail_idx), 128'd2);
    check_eq("t4_ff_xor", 128'(first_fail_xor), 128'h1);
    check_eq("t4_pass", 128'(pass), 128'd0);

    // T5: faults on idx 1 and 3; only the first is captured
    clear_inj();
    inj[1] = 80'h8;
    inj[3] = 80'h4;
    start_run(4);
    run_vectors(4, -1, 0, '0);
    check_eq("t5_count", 128'(mismatch_count), 128'd2);
    check_eq("t5_ff_idx", 128'(first_fail_idx), 128'd1);
    check_eq("t5_ff_xor", 128'(first_fail_xor), 128'h8);
    check_eq("t5_pass", 128'(pass), 128'd0);

    // T6: stall with start pulse while busy; idx 0 has X on bit 0 and bit 1 flipped
    clear_inj();
    inj[0]   = 80'h2;
    xflag[0] = 1'b1;
    start_run(2);
    run_vectors(2, 0, 3, vecs[3]);
    check_eq("t6_count", 128'(mismatch_count), 128'd1);
    check_eq("t6_ff_idx", 128'(first_fail_idx), 128'd0);
    check_eq("t6_ff_xor_hi", 128'(first_fail_xor[79:1]), 128'h1);
    check_eq("t6_pass", 128'(pass), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
